// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller.
// The state enum order fixes the StateDbg encoding.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluAnd = 2'b10;
    localparam logic [1:0] AluOrr = 2'b11;

    localparam logic [1:0] ResAluOut = 2'd0;
    localparam logic [1:0] ResRead   = 2'd1;
    localparam logic [1:0] ResAlu    = 2'd2;

    localparam logic [1:0] SrcBRd2  = 2'd0;
    localparam logic [1:0] SrcBImm  = 2'd1;
    localparam logic [1:0] SrcBFour = 2'd2;

    localparam logic [1:0] OpDp  = 2'b00;
    localparam logic [1:0] OpMem = 2'b01;
    localparam logic [1:0] OpBr  = 2'b10;

    localparam logic [3:0] CmdAnd = 4'b0000;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdCmp = 4'b1010;
    localparam logic [3:0] CmdOrr = 4'b1100;

    localparam logic [3:0] CondEq = 4'b0000;
    localparam logic [3:0] CondNe = 4'b0001;
    localparam logic [3:0] CondCs = 4'b0010;
    localparam logic [3:0] CondCc = 4'b0011;
    localparam logic [3:0] CondMi = 4'b0100;
    localparam logic [3:0] CondPl = 4'b0101;
    localparam logic [3:0] CondVs = 4'b0110;
    localparam logic [3:0] CondVc = 4'b0111;
    localparam logic [3:0] CondHi = 4'b1000;
    localparam logic [3:0] CondLs = 4'b1001;
    localparam logic [3:0] CondGe = 4'b1010;
    localparam logic [3:0] CondLt = 4'b1011;
    localparam logic [3:0] CondGt = 4'b1100;
    localparam logic [3:0] CondLe = 4'b1101;
    localparam logic [3:0] CondAl = 4'b1110;

    // Unsupported commands fall back to ADD (and are suppressed from writing).
    function automatic logic [1:0] cmd_alu(input logic [3:0] cmd);
        case (cmd)
            CmdSub, CmdCmp: cmd_alu = AluSub;
            CmdAnd:         cmd_alu = AluAnd;
            CmdOrr:         cmd_alu = AluOrr;
            default:        cmd_alu = AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/mc_cond_unit.sv
// NZCV flag register with split NZ / CV load enables, plus the ARM
// condition evaluation over the registered flags.
module mc_cond_unit
    import mc_pkg::*;
#(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nz_we_i,
    input  logic       cv_we_i,
    input  logic [3:0] alu_flags_i,
    input  logic [3:0] cond_i,
    output logic       cond_ex_o
);

    logic [3:0] flags_q, flags_d;
    logic       n, z, c, v;

    always_ff @(posedge clk) begin
        if (rst) flags_q <= FLAGS_RESET;
        else     flags_q <= flags_d;
    end

    always_comb begin
        flags_d = flags_q;
        if (nz_we_i) flags_d[3:2] = alu_flags_i[3:2];
        if (cv_we_i) flags_d[1:0] = alu_flags_i[1:0];
    end

    assign {n, z, c, v} = flags_q;

    always_comb begin
        case (cond_i)
            CondEq:  cond_ex_o = z;
            CondNe:  cond_ex_o = ~z;
            CondCs:  cond_ex_o = c;
            CondCc:  cond_ex_o = ~c;
            CondMi:  cond_ex_o = n;
            CondPl:  cond_ex_o = ~n;
            CondVs:  cond_ex_o = v;
            CondVc:  cond_ex_o = ~v;
            CondHi:  cond_ex_o = c & ~z;
            CondLs:  cond_ex_o = ~c | z;
            CondGe:  cond_ex_o = (n == v);
            CondLt:  cond_ex_o = (n != v);
            CondGt:  cond_ex_o = ~z & (n == v);
            CondLe:  cond_ex_o = z | (n != v);
            CondAl:  cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory port and ALU, stalling on MemReady.
module mc_controller
    import mc_pkg::*;
#(
    parameter state_t     RESET_STATE = FETCH,
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [3:0]  StateDbg
);

    state_t     state_q, state_d;
    logic [1:0] op;
    logic [3:0] cmd, rd;
    logic       cond_ex, dp_write, dp_arith, rd_pc, flag_upd;
    logic       pc_we, reg_we, ir_we, mem_we;
    logic       unused_instr;

    assign op       = Instr[27:26];
    assign cmd      = Instr[24:21];
    assign rd       = Instr[15:12];
    assign rd_pc    = (rd == 4'hF);
    assign dp_write = (cmd == CmdAdd) | (cmd == CmdSub) | (cmd == CmdAnd) | (cmd == CmdOrr);
    assign dp_arith = (cmd == CmdAdd) | (cmd == CmdSub) | (cmd == CmdCmp);
    assign flag_upd = ((state_q == EXECR) | (state_q == EXECI)) & (Instr[20] | (cmd == CmdCmp));
    assign unused_instr = ^{Instr[22], Instr[19:16], Instr[11:0]};

    mc_cond_unit #(
        .FLAGS_RESET (FLAGS_RESET)
    ) u_cond (
        .clk         (clk),
        .rst         (rst),
        .nz_we_i     (flag_upd),
        .cv_we_i     (flag_upd & dp_arith),
        .alu_flags_i (ALUFlags),
        .cond_i      (Instr[31:28]),
        .cond_ex_o   (cond_ex)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= RESET_STATE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:    if (MemReady) state_d = DECODE;
            DECODE: begin
                if (!cond_ex) begin
                    state_d = FETCH;
                end else begin
                    case (op)
                        OpMem:   state_d = MEMADR;
                        OpDp:    state_d = Instr[25] ? EXECI : EXECR;
                        OpBr:    state_d = BRANCH;
                        default: state_d = FETCH;
                    endcase
                end
            end
            MEMADR:   state_d = Instr[20] ? MEMREAD : MEMWRITE;
            MEMREAD:  if (MemReady) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (MemReady) state_d = FETCH;
            EXECR,
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        ir_we      = 1'b0;
        mem_we     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = ResAluOut;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SrcBRd2;
        ALUControl = AluAdd;
        unique case (state_q)
            FETCH: begin
                ir_we     = MemReady;
                pc_we     = MemReady;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAlu;
            end
            DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBFour;
            end
            MEMADR: begin
                ALUSrcB    = SrcBImm;
                ALUControl = Instr[23] ? AluAdd : AluSub;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = ResRead;
                pc_we     = rd_pc;
                reg_we    = ~rd_pc;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_we = 1'b1;
            end
            EXECR:    ALUControl = cmd_alu(cmd);
            EXECI: begin
                ALUSrcB    = SrcBImm;
                ALUControl = cmd_alu(cmd);
            end
            ALUWB: begin
                pc_we  = dp_write & rd_pc;
                reg_we = dp_write & ~rd_pc;
            end
            BRANCH: begin
                ALUSrcB   = SrcBImm;
                ResultSrc = ResAlu;
                pc_we     = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are masked combinationally so nothing fires on a reset cycle.
    assign PCWrite  = pc_we & ~rst;
    assign RegWrite = reg_we & ~rst;
    assign IRWrite  = ir_we & ~rst;
    assign MemWrite = mem_we & ~rst;
    assign ImmSrc   = op;
    assign RegSrc   = {op == OpMem, op == OpBr};
    assign StateDbg = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks ADD, LDR, STR, CMP/BEQ, ANDS and
// a mid-access reset, checking Moore outputs 2-3 ns after each rising edge.
module tb_mc_controller;

    logic        clk;
    logic        rst;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0]  StateDbg;

    int total = 0;
    int bad   = 0;

    mc_controller dut (
        .clk        (clk),
        .rst        (rst),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .StateDbg   (StateDbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; Instr = 32'h0; ALUFlags = 4'h0; MemReady = 1'b1;
        step(); step();
        check("rst_state", 32'(StateDbg), 32'd0);
        check("rst_pcw", 32'(PCWrite), 32'd0);
        check("rst_irw", 32'(IRWrite), 32'd0);
        check("rst_memw", 32'(MemWrite), 32'd0);
        check("rst_regw", 32'(RegWrite), 32'd0);
        check("rst_flags", 32'(dut.u_cond.flags_q), 32'h0);

        // ADD R1,R2,R3
        rst = 1'b0; Instr = 32'hE0821003; #1;
        check("add_c1_state", 32'(StateDbg), 32'd0);
        check("add_c1_irw", 32'(IRWrite), 32'd1);
        check("add_c1_pcw", 32'(PCWrite), 32'd1);
        check("add_c1_srcb", 32'(ALUSrcB), 32'd2);
        check("add_c1_res", 32'(ResultSrc), 32'd2);
        check("add_c1_regw", 32'(RegWrite), 32'd0);
        step();
        check("add_c2_state", 32'(StateDbg), 32'd1);
        check("add_c2_srca", 32'(ALUSrcA), 32'd1);
        check("add_c2_regw", 32'(RegWrite), 32'd0);
        step();
        check("add_c3_state", 32'(StateDbg), 32'd6);
        check("add_c3_srcb", 32'(ALUSrcB), 32'd0);
        check("add_c3_aluc", 32'(ALUControl), 32'd0);
        check("add_c3_regw", 32'(RegWrite), 32'd0);
        step();
        check("add_c4_state", 32'(StateDbg), 32'd8);
        check("add_c4_regw", 32'(RegWrite), 32'd1);
        check("add_c4_res", 32'(ResultSrc), 32'd0);
        check("add_c4_pcw", 32'(PCWrite), 32'd0);
        step();
        check("add_c5_state", 32'(StateDbg), 32'd0);

        // LDR R0,[R1,#4] with two stall cycles in MEMREAD
        Instr = 32'hE5910004;
        step();
        check("ldr_dec_regsrc", 32'(RegSrc), 32'd2);
        check("ldr_dec_immsrc", 32'(ImmSrc), 32'd1);
        step();
        check("ldr_madr_state", 32'(StateDbg), 32'd2);
        check("ldr_madr_aluc", 32'(ALUControl), 32'd0);
        check("ldr_madr_srcb", 32'(ALUSrcB), 32'd1);
        step();
        MemReady = 1'b0; #1;
        check("ldr_rd1_state", 32'(StateDbg), 32'd3);
        check("ldr_rd1_adr", 32'(AdrSrc), 32'd1);
        step();
        check("ldr_rd2_state", 32'(StateDbg), 32'd3);
        check("ldr_rd2_adr", 32'(AdrSrc), 32'd1);
        step();
        check("ldr_rd3_state", 32'(StateDbg), 32'd3);
        MemReady = 1'b1;
        step();
        check("ldr_wb_state", 32'(StateDbg), 32'd4);
        check("ldr_wb_regw", 32'(RegWrite), 32'd1);
        check("ldr_wb_res", 32'(ResultSrc), 32'd1);
        check("ldr_wb_pcw", 32'(PCWrite), 32'd0);
        step();
        check("ldr_done_state", 32'(StateDbg), 32'd0);

        // STR R0,[R1,#-8] with one stall cycle in MEMWRITE
        Instr = 32'hE5010008;
        step(); step();
        check("str_madr_aluc", 32'(ALUControl), 32'd1);
        step();
        MemReady = 1'b0; #1;
        check("str_w1_state", 32'(StateDbg), 32'd5);
        check("str_w1_memw", 32'(MemWrite), 32'd1);
        check("str_w1_regw", 32'(RegWrite), 32'd0);
        step();
        MemReady = 1'b1; #1;
        check("str_w2_memw", 32'(MemWrite), 32'd1);
        step();
        check("str_done_state", 32'(StateDbg), 32'd0);
        check("str_done_memw", 32'(MemWrite), 32'd0);

        // CMP R1,R1 setting Z, then BEQ taken
        Instr = 32'hE1510001;
        step(); step();
        ALUFlags = 4'b0110; #1;
        check("cmp1_exec_aluc", 32'(ALUControl), 32'd1);
        step();
        ALUFlags = 4'b0000;
        check("cmp1_wb_regw", 32'(RegWrite), 32'd0);
        check("cmp1_wb_pcw", 32'(PCWrite), 32'd0);
        check("cmp1_flags", 32'(dut.u_cond.flags_q), 32'h6);
        step();
        Instr = 32'h0A000002;
        step();
        check("beq1_dec_regsrc", 32'(RegSrc), 32'd1);
        check("beq1_dec_pcw", 32'(PCWrite), 32'd0);
        step();
        check("beq1_br_state", 32'(StateDbg), 32'd9);
        check("beq1_br_pcw", 32'(PCWrite), 32'd1);
        check("beq1_br_srcb", 32'(ALUSrcB), 32'd1);
        step();
        check("beq1_done_state", 32'(StateDbg), 32'd0);

        // CMP clearing Z, then BEQ not taken
        Instr = 32'hE1510001;
        step(); step();
        ALUFlags = 4'b0000;
        step();
        check("cmp2_flags", 32'(dut.u_cond.flags_q), 32'h0);
        step();
        Instr = 32'h0A000002;
        step();
        check("beq2_dec_pcw", 32'(PCWrite), 32'd0);
        step();
        check("beq2_skip_state", 32'(StateDbg), 32'd0);

        // ANDS R0,R1,R2: NZ load, CV untouched
        Instr = 32'hE0110002;
        step(); step();
        ALUFlags = 4'b1111; #1;
        check("ands_exec_aluc", 32'(ALUControl), 32'd2);
        step();
        ALUFlags = 4'b0000;
        check("ands_wb_regw", 32'(RegWrite), 32'd1);
        check("ands_flags", 32'(dut.u_cond.flags_q), 32'hC);
        step();

        // Reset while MEMWRITE is stalled
        Instr = 32'hE5010008;
        step(); step(); step();
        MemReady = 1'b0; #1;
        check("rstw_pre_memw", 32'(MemWrite), 32'd1);
        rst = 1'b1; #1;
        check("rstw_gate_memw", 32'(MemWrite), 32'd0);
        step();
        check("rstw_state", 32'(StateDbg), 32'd0);
        check("rstw_memw", 32'(MemWrite), 32'd0);
        check("rstw_flags", 32'(dut.u_cond.flags_q), 32'h0);
        rst = 1'b0; MemReady = 1'b1; #1;
        check("rstw_fetch_irw", 32'(IRWrite), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle control FSM for the ARM-subset core. It replaces the single-cycle controller when the datapath shares one memory port and one ALU across cycles. It sequences fetch, decode, execute, memory and writeback, owns the NZCV flag register and condition evaluation, and stalls on a memory-ready handshake.

Parameters:
RESET_STATE, FETCH, state the FSM enters on reset
FLAGS_RESET, 4'b0000, reset value of the NZCV register

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
Instr  in  32  instruction register contents, valid from DECODE onward
ALUFlags  in  4  {N,Z,C,V} from the ALU this cycle
MemReady  in  1  memory completes the current access this cycle
PCWrite  out  1  load the PC
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  load the instruction register
ResultSrc  out  2  0 = ALUOut, 1 = ReadData, 2 = ALU result direct
ALUSrcA  out  1  0 = RD1 register, 1 = PC
ALUSrcB  out  2  0 = RD2, 1 = ExtImm, 2 = constant 4
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ImmSrc  out  2  equals Instr[27:26]
RegSrc  out  2  [0] = (Op==10), [1] = (Op==01)
RegWrite  out  1  register file write enable
StateDbg  out  4  current state encoding

Behaviour:
- Reset is synchronous. On the first edge with rst=1: state=FETCH and flags=FLAGS_RESET. While in reset, all strobes (PCWrite, MemWrite, IRWrite, RegWrite) are 0. Reset mid-access aborts the access; no strobe fires on the reset cycle.
- Outputs are Moore-style, decoded from state and Instr only. Unlisted outputs are 0.
- FETCH:
  - Drives AdrSrc=0, ALUSrcA=1, ALUSrcB=2, ADD, ResultSrc=2.
  - IRWrite and PCWrite are asserted only when MemReady=1. Go to DECODE when MemReady=1, else hold.
- DECODE:
  - Drives ALUSrcA=1, ALUSrcB=2, ADD. This computes PC+8 for R15 reads.
  - If CondEx=0, go to FETCH.
  - Otherwise: Op=01 goes to MEMADR; Op=00 with Funct[5]=0 goes to EXECR; Op=00 with Funct[5]=1 goes to EXECI; Op=10 goes to BRANCH; Op=11 goes to FETCH (nop).
- MEMADR:
  - Drives ALUSrcA=0, ALUSrcB=1. ALUControl is ADD if U=Instr[23]=1, else SUB.
  - L=Instr[20]=1 goes to MEMREAD; L=0 goes to MEMWRITE.
- MEMREAD: AdrSrc=1. Hold until MemReady=1, then go to MEMWB.
- MEMWB: ResultSrc=1. If Rd==15, assert PCWrite=1 instead of RegWrite; otherwise RegWrite=1. Then go to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held every cycle until MemReady=1, then go to FETCH.
- EXECR / EXECI:
  - ALUSrcA=0. ALUSrcB is 0 in EXECR and 1 in EXECI.
  - cmd=Instr[24:21] maps as: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no write). Any other cmd is ADD with no write.
  - Go to ALUWB.
- Flag update at the end of EXECR/EXECI, when S=Instr[20]=1 or cmd=CMP:
  - NZ always load from ALUFlags[3:2].
  - CV load from ALUFlags[1:0] only for ADD/SUB/CMP.
  - Updated flags are visible to the next instruction's DECODE.
- ALUWB: ResultSrc=0. If write is enabled and Rd≠15, RegWrite=1. If write is enabled and Rd==15, PCWrite=1. CMP and unsupported ops write nothing. Then go to FETCH.
- BRANCH: ALUSrcA=0 (RD1=PC+8 via RegSrc[0]), ALUSrcB=1, ADD, ResultSrc=2, PCWrite=1. Then go to FETCH.
- CondEx follows the full ARM condition table over the registered NZCV. 1110 (AL) is 1; 1111 is 0.
- Cycle counts with MemReady=1 throughout: data-processing 4, LDR 5, STR 4, B 3, condition-failed 2.
- MemReady held low stalls indefinitely in FETCH, MEMREAD or MEMWRITE. No other state samples MemReady.

Decomposition:
- Package mc_pkg holds:
  - state_t enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
  - ALUControl, ResultSrc and ALUSrcB encoding constants.
  - cmd constants.
  - Cond code constants.
- One sub-module, mc_cond_unit, holds the NZCV register with its update enables, plus the CondEx combinational evaluation.

Test Plan:
- Reset: rst=1 for 2 cycles, then release. StateDbg=FETCH, all strobes 0, flags 0000.
- ADD R1,R2,R3 (E0821003), MemReady=1:
  - States run FETCH→DECODE→EXECR→ALUWB.
  - RegWrite=1 only in cycle 4.
  - Back in FETCH at cycle 5.
- LDR R0,[R1,#4] (E5910004), MemReady low for 2 cycles in MEMREAD:
  - MEMREAD lasts 3 cycles with AdrSrc=1.
  - MEMWB asserts RegWrite with ResultSrc=1.
  - Total 7 cycles.
- STR R0,[R1,#-8] (E5010008):
  - MEMADR drives ALUControl=SUB.
  - MemWrite=1 in MEMWRITE until MemReady. RegWrite is never asserted.
- SUBS CMP R1,R1 (E1510001), then BEQ (0A000002):
  - Z is set after EXECR.
  - BEQ goes through BRANCH with PCWrite=1.
  - Repeat with Z=0: DECODE→FETCH, no PCWrite.
- Reset asserted while MEMWRITE is stalled: MemWrite drops on the reset edge, next state is FETCH, flags return to 0000.
